// File: rtl/umi_port_arbiter.sv
// Per-output-port arbiter for the UMI crossbar: fixed-priority, round-robin and aged
// round-robin grant selection, with the grant held across sink backpressure.
module umi_port_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned AGEW    = 4,
  parameter int unsigned AGE_MAX = 12
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [1:0]   mode,
  input  logic [N-1:0] mask,
  input  logic [N-1:0] umi_in_request,
  output logic [N-1:0] umi_in_ready,
  output logic         umi_out_valid,
  input  logic         umi_out_ready,
  output logic [N-1:0] grant,
  output logic [N-1:0] starved
);

  localparam int unsigned IW = $clog2(N);
  localparam logic [AGEW-1:0] AgeMax = AGEW'(AGE_MAX);
  localparam logic [AGEW-1:0] AgeSat = {AGEW{1'b1}};

  logic            en_q;
  logic            hold_q;
  logic [IW-1:0]   hold_idx_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   ptr_d;
  logic [AGEW-1:0] age_q [N];
  logic [AGEW-1:0] age_d [N];
  logic [N-1:0]    starved_q;

  logic [N-1:0]    req;
  logic [N-1:0]    aged;
  logic [IW-1:0]   gidx;
  logic [IW-1:0]   rr_idx;
  logic            gany;
  logic            xfer;

  assign req = umi_in_request & ~mask;

  // Loops run from the lowest priority candidate upward so the last hit is the winner.
  always_comb begin
    gidx   = '0;
    gany   = 1'b0;
    rr_idx = '0;
    for (int i = 0; i < int'(N); i++) begin
      aged[i] = req[i] && (age_q[i] >= AgeMax);
    end
    if (en_q) begin
      if (hold_q && req[hold_idx_q]) begin
        gany = 1'b1;
        gidx = hold_idx_q;
      end else if (mode == 2'b00 || (mode[1] && |aged)) begin
        for (int i = int'(N) - 1; i >= 0; i--) begin
          if (mode == 2'b00 ? req[i] : aged[i]) begin
            gany = 1'b1;
            gidx = IW'(i);
          end
        end
      end else begin
        for (int k = int'(N) - 1; k >= 0; k--) begin
          rr_idx = IW'((int'(ptr_q) + k) % int'(N));
          if (req[rr_idx]) begin
            gany = 1'b1;
            gidx = rr_idx;
          end
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    if (gany) begin
      grant[gidx] = 1'b1;
    end
  end

  assign umi_out_valid = gany;
  assign umi_in_ready  = grant & {N{umi_out_ready}};
  assign xfer          = gany & umi_out_ready;
  assign starved       = starved_q;
  assign ptr_d         = (gidx == IW'(N - 1)) ? '0 : gidx + 1'b1;

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      if (!req[i] || (xfer && gidx == IW'(i))) begin
        age_d[i] = '0;
      end else if (age_q[i] != AgeSat) begin
        age_d[i] = age_q[i] + 1'b1;
      end else begin
        age_d[i] = age_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      en_q       <= 1'b0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
      ptr_q      <= '0;
      starved_q  <= '0;
      for (int i = 0; i < int'(N); i++) begin
        age_q[i] <= '0;
      end
    end else begin
      en_q   <= 1'b1;
      hold_q <= gany & ~umi_out_ready;
      if (gany && !umi_out_ready) begin
        hold_idx_q <= gidx;
      end
      if (xfer && mode != 2'b00) begin
        ptr_q <= ptr_d;
      end
      for (int i = 0; i < int'(N); i++) begin
        age_q[i]     <= age_d[i];
        starved_q[i] <= (age_d[i] >= AgeMax);
      end
    end
  end

endmodule

// File: tb/tb_umi_port_arbiter.sv
// Scoreboard bench for umi_port_arbiter: a behavioural model predicts each cycle's outputs,
// and an independent negedge monitor pops and compares them.
module tb_umi_port_arbiter;

  localparam int unsigned N       = 4;
  localparam int unsigned AGEW    = 4;
  localparam int unsigned AGE_MAX = 12;

  logic         clk = 1'b0;
  logic         nreset;
  logic [1:0]   mode;
  logic [N-1:0] mask;
  logic [N-1:0] req_in;
  logic [N-1:0] in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] grant;
  logic [N-1:0] starved;

  always #5 clk = ~clk;

  umi_port_arbiter #(
    .N       (N),
    .AGEW    (AGEW),
    .AGE_MAX (AGE_MAX)
  ) dut (
    .clk            (clk),
    .nreset         (nreset),
    .mode           (mode),
    .mask           (mask),
    .umi_in_request (req_in),
    .umi_in_ready   (in_ready),
    .umi_out_valid  (out_valid),
    .umi_out_ready  (out_ready),
    .grant          (grant),
    .starved        (starved)
  );

  typedef struct packed {
    logic [N-1:0] grant;
    logic [N-1:0] in_ready;
    logic         valid;
    logic [N-1:0] starved;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  bit m_en;
  bit m_hold;
  int m_held;
  int m_ptr;
  int m_age[N];
  int m_gi;
  bit m_xfer;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en   = 1'b0;
    m_hold = 1'b0;
    m_held = 0;
    m_ptr  = 0;
    m_gi   = -1;
    m_xfer = 1'b0;
    for (int i = 0; i < int'(N); i++) m_age[i] = 0;
  endtask

  // Predicts this cycle's outputs from the current inputs, then advances to the post-edge state.
  task automatic model_cycle(input bit push);
    logic [N-1:0] r;
    exp_t         e;
    int           gi;
    int           sat;
    r   = req_in & ~mask;
    gi  = -1;
    sat = (1 << AGEW) - 1;
    if (m_en) begin
      if (m_hold && r[m_held]) begin
        gi = m_held;
      end else if (mode == 2'b00) begin
        for (int i = 0; i < int'(N); i++) if (r[i]) begin gi = i; break; end
      end else begin
        if (mode[1]) begin
          for (int i = 0; i < int'(N); i++) begin
            if (r[i] && m_age[i] >= int'(AGE_MAX)) begin gi = i; break; end
          end
        end
        if (gi < 0) begin
          for (int k = 0; k < int'(N); k++) begin
            int j;
            j = (m_ptr + k) % int'(N);
            if (r[j]) begin gi = j; break; end
          end
        end
      end
    end
    e.grant = '0;
    if (gi >= 0) e.grant[gi] = 1'b1;
    e.valid    = (gi >= 0);
    e.in_ready = out_ready ? e.grant : '0;
    for (int i = 0; i < int'(N); i++) e.starved[i] = (m_age[i] >= int'(AGE_MAX));
    if (push) sb_q.push_back(e);

    m_gi   = gi;
    m_xfer = (gi >= 0) && out_ready;
    m_hold = (gi >= 0) && !out_ready;
    if (m_hold) m_held = gi;
    if (m_xfer && mode != 2'b00) m_ptr = (gi + 1) % int'(N);
    for (int i = 0; i < int'(N); i++) begin
      if (!r[i] || (m_xfer && gi == i)) m_age[i] = 0;
      else if (m_age[i] < sat) m_age[i] = m_age[i] + 1;
    end
    m_en = 1'b1;
  endtask

  task automatic drive(input logic [1:0] md, input logic [N-1:0] mk, input logic [N-1:0] rq,
                       input logic rdy);
    @(posedge clk);
    #1;
    mode      = md;
    mask      = mk;
    req_in    = rq;
    out_ready = rdy;
    model_cycle(1'b1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check("grant", 32'(grant), 32'(mon_e.grant));
        check("umi_in_ready", 32'(in_ready), 32'(mon_e.in_ready));
        check("umi_out_valid", 32'(out_valid), 32'(mon_e.valid));
        check("starved", 32'(starved), 32'(mon_e.starved));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] rq;
    logic [N-1:0] mk;
    logic [1:0]   md;

    nreset    = 1'b0;
    mode      = 2'b00;
    mask      = '0;
    req_in    = '0;
    out_ready = 1'b0;
    model_reset();
    #2;
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_valid", 32'(out_valid), 32'h0);
    check("reset_starved", 32'(starved), 32'h0);
    @(posedge clk);
    @(negedge clk);
    #1;
    nreset = 1'b1;
    model_cycle(1'b0);

    // Fixed priority
    repeat (8) drive(2'b00, '0, 4'b1111, 1'b1);
    // Round robin, pointer wraps
    repeat (8) drive(2'b01, '0, 4'b1111, 1'b1);
    // Backpressure lock then release
    repeat (3) drive(2'b01, '0, 4'b0110, 1'b0);
    repeat (2) drive(2'b01, '0, 4'b0110, 1'b1);
    // Starve index 3 under fixed priority, then let aged RR rescue it
    repeat (14) drive(2'b00, '0, 4'b1001, 1'b1);
    repeat (3) drive(2'b10, '0, 4'b1001, 1'b1);
    // Mask the held requester
    repeat (2) drive(2'b01, '0, 4'b0100, 1'b0);
    drive(2'b01, 4'b0100, 4'b0110, 1'b0);
    repeat (2) drive(2'b01, '0, 4'b0110, 1'b1);
    // Async reset mid-lock
    repeat (2) drive(2'b01, '0, 4'b0010, 1'b0);
    @(negedge clk);
    #1;
    nreset    = 1'b0;
    req_in    = '0;
    out_ready = 1'b0;
    mode      = 2'b00;
    mask      = '0;
    #1;
    check("midreset_grant", 32'(grant), 32'h0);
    check("midreset_valid", 32'(out_valid), 32'h0);
    check("midreset_in_ready", 32'(in_ready), 32'h0);
    check("midreset_starved", 32'(starved), 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1;
    nreset    = 1'b1;
    mode      = 2'b01;
    req_in    = 4'b1111;
    out_ready = 1'b1;
    #1;
    check("pre_enable_grant", 32'(grant), 32'h0);
    model_cycle(1'b0);
    repeat (4) drive(2'b01, '0, 4'b1111, 1'b1);

    // Randomized traffic with sticky requests
    rq = '0;
    md = 2'b01;
    for (int c = 0; c < 3000; c++) begin
      if (c % 25 == 0) md = 2'($urandom_range(0, 3));
      mk = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
      for (int i = 0; i < int'(N); i++) begin
        if (rq[i] && !(m_xfer && m_gi == i)) rq[i] = ($urandom_range(0, 19) != 0);
        else rq[i] = ($urandom_range(0, 2) == 0);
      end
      drive(md, mk, rq, ($urandom_range(0, 9) < 7));
    end

    repeat (2) @(posedge clk);
    check("scoreboard_drain", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/umi_port_arbiter.md
# umi_port_arbiter

Per-output-port arbiter for the UMI crossbar. It takes the N request lines that target one output port and issues a one-hot grant to one requester. It returns ready to the winning input and valid to the output sink. It supports fixed-priority, round-robin and aged round-robin policies, and holds a grant across backpressure. One instance sits on each output column of the crossbar datapath.

## Interface
- N, 4: number of requesting input ports (≥2).
- AGEW, 4: width of each per-requester starvation counter.
- AGE_MAX, 12: starvation threshold in cycles, < 2^AGEW.
- clk, input, 1: clock.
- nreset, input, 1: asynchronous active-low reset.
- mode, input, 2: policy selection.
  - 00: fixed priority, index 0 highest.
  - 01: round robin.
  - 10: aged round robin.
  - 11: same as 10.
- mask, input, N: 1 excludes that requester from arbitration.
- umi_in_request, input, N: requester i wants this output. Stays high until transferred.
- umi_in_ready, output, N: equals grant[i] & umi_out_ready.
- umi_out_valid, output, 1: OR of grant.
- umi_out_ready, input, 1: sink accepts the current beat.
- grant, output, N: one-hot (or zero) select driving the crossbar data mux.
- starved, output, N: age counter of requester i has reached AGE_MAX (registered).

## Operation
- Effective request: req = umi_in_request & ~mask.
- Transfer: umi_out_valid & umi_out_ready.
- State:
  - ptr: rotating priority pointer, log2(N) bits, reset 0.
  - hold: 1 bit, reset 0.
  - hold_idx: log2(N) bits, reset 0.
  - age[i]: AGEW-bit counter, reset 0.
  - en: reset 0, set on the first clk edge after nreset deasserts.
- Grant selection (combinational, same cycle):
  - If en=0: grant=0.
  - If hold=1 and req[hold_idx]=1: grant = onehot(hold_idx). Lock wins over every policy.
  - If hold=1 and req[hold_idx]=0: the requester withdrew or was masked. Lock is released and a fresh selection is made this cycle.
  - mode 00: lowest-index set bit of req.
  - mode 01: first set bit of req scanning ptr, ptr+1, … wrapping modulo N.
  - mode 1x: if any req[i] has age[i] ≥ AGE_MAX, grant the lowest such index. Otherwise same as 01.
  - req = 0: grant = 0, umi_out_valid = 0.
- Hold:
  - On a cycle with grant≠0 and umi_out_ready=0: hold←1, hold_idx←granted index.
  - On a transfer: hold←0.
- Pointer:
  - On a transfer in mode 01/1x: ptr ← (granted index + 1) mod N.
  - In mode 00, ptr is unchanged.
  - ptr is never updated without a transfer.
- Age counters:
  - Cleared when that requester transfers, or when req[i]=0.
  - Otherwise increment when req[i]=1 and i not transferring.
  - Saturate at 2^AGEW−1.
  - Counters run in all modes; only mode 1x acts on them.
  - starved[i] ← (next age[i] ≥ AGE_MAX).
- A mode or mask change takes effect combinationally the next cycle it is sampled. Hold is still honoured unless the held requester becomes masked.

## Timing
- Request to grant: 0 cycles (combinational), once en=1.
- Back-to-back transfers are allowed every cycle. Full throughput with umi_out_ready held high.
- Asynchronous reset mid-operation:
  - Forces all state to reset values.
  - grant, umi_in_ready, umi_out_valid go 0 immediately.
  - starved = 0.
- First grant after release: the cycle following the first clk rising edge with nreset high.
- Simultaneous events:
  - A transfer and a new lock cannot coincide: a lock needs ready=0.
  - A transfer of the held requester clears hold and advances ptr on the same edge.
- Wrap: ptr at N−1 with a transfer from index N−1 gives ptr=0.

## Test plan
- Fixed priority:
  - Stimulus: mode=00, N=4, req=1111, ready=1, 8 cycles.
  - Required: grant=0001 every cycle; ptr stays 0; age[1..3] reach 8.
- Round robin:
  - Stimulus: mode=01, req=1111, ready=1.
  - Required: grants 0001, 0010, 0100, 1000, 0001, …; ptr wraps 3→0.
- Backpressure lock:
  - Stimulus: mode=01, req=0110, ready=0 for 3 cycles, then 1.
  - Required: grant=0010 for all 4 cycles; umi_in_ready=0000 then 0010; next grant=0100.
- Aging:
  - Stimulus: mode=10, AGE_MAX=12; req[3] held continuously; req[0..2] kept high with ptr steered so index 3 loses.
  - Required: starved[3]=1 after 12 lost cycles; next grant=1000; age[3] clears to 0 after that transfer.
- Mask and withdrawal:
  - Stimulus: lock held on index 2 (ready=0), then mask=0100.
  - Required: same cycle grant moves to the next req after ptr, or to 0000 if none; no transfer is recorded for index 2.
- Reset mid-lock:
  - Stimulus: hold=1 on index 1, assert nreset low between clock edges.
  - Required: grant=0000 and umi_out_valid=0 immediately; after release, first grant one cycle later from ptr=0.
